// File: rtl/clip_pkg.sv
// Shared types and constants for the clip recorder front-panel control stage.
package clip_pkg;

    // Control states of the recorder front panel.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } clip_state_t;

    // Clip index as shown on one seven-segment digit.
    typedef logic [3:0] clip_idx_t;

    // Display code that blanks the digit.
    localparam clip_idx_t CLIP_NONE = 4'hF;

    // Step the selection cursor forward, wrapping from last back to 0.
    function automatic clip_idx_t sel_next(input clip_idx_t cur, input clip_idx_t last);
        return (cur == last) ? 4'd0 : cur + 4'd1;
    endfunction

    // Step the selection cursor backward, wrapping from 0 to last.
    function automatic clip_idx_t sel_prev(input clip_idx_t cur, input clip_idx_t last);
        return (cur == 4'd0) ? last : cur - 4'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Debouncer for one raw push-button: synchronizes the pin, accepts a new
// level only after it has been stable for DEBOUNCE_CYCLES consecutive cycles,
// and emits a single-cycle pulse when the accepted level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic button_i,
    output logic pressed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_ff1;
    logic             sync_ff2;
    logic             accepted;
    logic [CNT_W-1:0] count;

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
        end else begin
            sync_ff1 <= button_i;
            sync_ff2 <= sync_ff1;
        end
    end

    // Count consecutive disagreeing cycles; flip the accepted level and pulse on a rise.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            accepted  <= 1'b0;
            count     <= '0;
            pressed_o <= 1'b0;
        end else begin
            pressed_o <= 1'b0;
            if (sync_ff2 == accepted) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                accepted  <= sync_ff2;
                count     <= '0;
                pressed_o <= sync_ff2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clip_controller.sv
// Front-panel control for the clip recorder: debounces the four buttons,
// tracks the selected clip, runs the idle/record/play state machine and
// drives registered display digits and audio-path enables.
module clip_controller
    import clip_pkg::*;
#(
    parameter int SYSTEM_FREQUENCY = 100000000,
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int NUM_CLIPS        = 10
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 btn_next_i,
    input  logic                 btn_prev_i,
    input  logic                 btn_record_i,
    input  logic                 btn_play_i,
    input  logic                 clip_done_i,
    output clip_idx_t            record_clip_o,
    output clip_idx_t            play_clip_o,
    output logic                 recording_o,
    output logic                 playing_o,
    output logic [NUM_CLIPS-1:0] clip_valid_o,
    output clip_state_t          state_o
);

    localparam clip_idx_t LAST_CLIP = 4'(NUM_CLIPS - 1);

    logic next_p;
    logic prev_p;
    logic record_p;
    logic play_p;

    clip_state_t          state;
    clip_state_t          state_n;
    clip_idx_t            sel;
    clip_idx_t            sel_n;
    logic [NUM_CLIPS-1:0] valid_n;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .button_i (btn_next_i),
        .pressed_o(next_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .button_i (btn_prev_i),
        .pressed_o(prev_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_record (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .button_i (btn_record_i),
        .pressed_o(record_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .button_i (btn_play_i),
        .pressed_o(play_p)
    );

    // Next state, selection and valid map. In IDLE only the highest-priority
    // press acts (record > play > next > prev); a play press on an empty
    // slot still wins priority and is simply dropped.
    always_comb begin
        state_n = state;
        sel_n   = sel;
        valid_n = clip_valid_o;
        case (state)
            IDLE: begin
                if (record_p) begin
                    state_n = RECORD;
                end else if (play_p) begin
                    if (clip_valid_o[sel]) begin
                        state_n = PLAY;
                    end
                end else if (next_p) begin
                    sel_n = sel_next(sel, LAST_CLIP);
                end else if (prev_p) begin
                    sel_n = sel_prev(sel, LAST_CLIP);
                end
            end
            RECORD: begin
                if (record_p || clip_done_i) begin
                    state_n      = IDLE;
                    valid_n[sel] = 1'b1;
                end
            end
            PLAY: begin
                if (play_p || clip_done_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, selection and valid registers plus outputs derived from the
    // next values, so every output changes on the same edge as the state.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state         <= IDLE;
            sel           <= 4'd0;
            clip_valid_o  <= '0;
            record_clip_o <= 4'd0;
            play_clip_o   <= CLIP_NONE;
            recording_o   <= 1'b0;
            playing_o     <= 1'b0;
        end else begin
            state         <= state_n;
            sel           <= sel_n;
            clip_valid_o  <= valid_n;
            record_clip_o <= (state_n == PLAY) ? CLIP_NONE : sel_n;
            play_clip_o   <= (state_n == PLAY) ? sel_n : CLIP_NONE;
            recording_o   <= (state_n == RECORD);
            playing_o     <= (state_n == PLAY);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_clip_controller.sv
// Directed testbench for clip_controller with a short debounce window.
module tb_clip_controller;
    import clip_pkg::*;

    localparam int DEB  = 4;
    localparam int NCL  = 10;

    logic           clock_i;
    logic           reset_i;
    logic           btn_next_i;
    logic           btn_prev_i;
    logic           btn_record_i;
    logic           btn_play_i;
    logic           clip_done_i;
    logic [3:0]     record_clip_o;
    logic [3:0]     play_clip_o;
    logic           recording_o;
    logic           playing_o;
    logic [NCL-1:0] clip_valid_o;
    clip_state_t    state_o;

    int checks = 0;
    int errors = 0;

    clip_controller #(
        .SYSTEM_FREQUENCY(100000000),
        .DEBOUNCE_CYCLES (DEB),
        .NUM_CLIPS       (NCL)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .btn_next_i   (btn_next_i),
        .btn_prev_i   (btn_prev_i),
        .btn_record_i (btn_record_i),
        .btn_play_i   (btn_play_i),
        .clip_done_i  (clip_done_i),
        .record_clip_o(record_clip_o),
        .play_clip_o  (play_clip_o),
        .recording_o  (recording_o),
        .playing_o    (playing_o),
        .clip_valid_o (clip_valid_o),
        .state_o      (state_o)
    );

    // Clock
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Drive a button mask {play, record, prev, next} for 10 cycles, release, settle.
    task automatic press(input logic [3:0] mask);
        {btn_play_i, btn_record_i, btn_prev_i, btn_next_i} = mask;
        repeat (10) @(negedge clock_i);
        {btn_play_i, btn_record_i, btn_prev_i, btn_next_i} = 4'b0000;
        repeat (10) @(negedge clock_i);
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        {btn_play_i, btn_record_i, btn_prev_i, btn_next_i} = 4'b0000;
        clip_done_i = 1'b0;
        repeat (3) @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        checks++;
        if (record_clip_o !== 4'h0 || play_clip_o !== 4'hF || recording_o !== 1'b0 ||
            playing_o !== 1'b0 || clip_valid_o !== '0 || state_o !== IDLE) begin
            errors++;
            $display("FAIL reset: rec=%h play=%h r=%b p=%b valid=%b state=%0d expected 0 F 0 0 0 IDLE",
                     record_clip_o, play_clip_o, recording_o, playing_o, clip_valid_o, state_o);
        end
    endtask

    task automatic test_select();
        logic [3:0] masks [7];
        logic [3:0] exp   [7];
        masks = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp   = '{4'd9, 4'd8, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
        for (int i = 0; i < 7; i++) begin
            press(masks[i]);
            checks++;
            if (record_clip_o !== exp[i]) begin
                errors++;
                $display("FAIL select step %0d: record_clip_o=%0d expected %0d", i, record_clip_o, exp[i]);
            end
        end
        press(4'b0010);
        checks++;
        if (record_clip_o !== 4'd0) begin
            errors++;
            $display("FAIL select back to 0: record_clip_o=%0d expected 0", record_clip_o);
        end
    endtask

    task automatic test_play_unrecorded();
        press(4'b1000);
        checks++;
        if (state_o !== IDLE || playing_o !== 1'b0 || play_clip_o !== 4'hF) begin
            errors++;
            $display("FAIL play empty: state=%0d playing=%b play_clip=%h expected IDLE 0 F",
                     state_o, playing_o, play_clip_o);
        end
        press(4'b0100);
        checks++;
        if (recording_o !== 1'b1 || record_clip_o !== 4'd0 || play_clip_o !== 4'hF) begin
            errors++;
            $display("FAIL record start: recording=%b rec=%h play=%h expected 1 0 F",
                     recording_o, record_clip_o, play_clip_o);
        end
        clip_done_i = 1'b1;
        @(negedge clock_i);
        clip_done_i = 1'b0;
        checks++;
        if (recording_o !== 1'b0 || clip_valid_o !== 10'b0000000001) begin
            errors++;
            $display("FAIL record done: recording=%b valid=%b expected 0 0000000001",
                     recording_o, clip_valid_o);
        end
        press(4'b1000);
        checks++;
        if (playing_o !== 1'b1 || play_clip_o !== 4'd0 || record_clip_o !== 4'hF) begin
            errors++;
            $display("FAIL play start: playing=%b play=%h rec=%h expected 1 0 F",
                     playing_o, play_clip_o, record_clip_o);
        end
    endtask

    task automatic test_reset_mid_play();
        @(negedge clock_i);
        #2 reset_i = 1'b0;
        #1;
        checks++;
        if (record_clip_o !== 4'h0 || play_clip_o !== 4'hF || recording_o !== 1'b0 ||
            playing_o !== 1'b0 || clip_valid_o !== '0) begin
            errors++;
            $display("FAIL reset mid play: rec=%h play=%h r=%b p=%b valid=%b expected 0 F 0 0 0",
                     record_clip_o, play_clip_o, recording_o, playing_o, clip_valid_o);
        end
        @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            btn_next_i = 1'b1;
            repeat (3) @(negedge clock_i);
            btn_next_i = 1'b0;
            repeat (3) @(negedge clock_i);
        end
        repeat (10) @(negedge clock_i);
        checks++;
        if (record_clip_o !== 4'd0 || state_o !== IDLE) begin
            errors++;
            $display("FAIL bounce: record_clip_o=%0d state=%0d expected 0 IDLE", record_clip_o, state_o);
        end
        btn_next_i = 1'b1;
        repeat (6) @(negedge clock_i);
        checks++;
        if (record_clip_o !== 4'd0) begin
            errors++;
            $display("FAIL latency cycle 6: record_clip_o=%0d expected 0", record_clip_o);
        end
        @(negedge clock_i);
        checks++;
        if (record_clip_o !== 4'd1) begin
            errors++;
            $display("FAIL latency cycle 7: record_clip_o=%0d expected 1", record_clip_o);
        end
        repeat (3) @(negedge clock_i);
        btn_next_i = 1'b0;
        repeat (10) @(negedge clock_i);
        checks++;
        if (record_clip_o !== 4'd1) begin
            errors++;
            $display("FAIL single pulse on hold: record_clip_o=%0d expected 1", record_clip_o);
        end
    endtask

    task automatic test_simultaneous();
        press(4'b0101);
        checks++;
        if (recording_o !== 1'b1 || record_clip_o !== 4'd1) begin
            errors++;
            $display("FAIL record+next: recording=%b rec=%0d expected 1 1", recording_o, record_clip_o);
        end
        press(4'b0001);
        checks++;
        if (recording_o !== 1'b1 || record_clip_o !== 4'd1) begin
            errors++;
            $display("FAIL next in record: recording=%b rec=%0d expected 1 1", recording_o, record_clip_o);
        end
        press(4'b0100);
        checks++;
        if (recording_o !== 1'b0 || clip_valid_o !== 10'b0000000010) begin
            errors++;
            $display("FAIL record stop: recording=%b valid=%b expected 0 0000000010", recording_o, clip_valid_o);
        end
        press(4'b1001);
        checks++;
        if (playing_o !== 1'b1 || play_clip_o !== 4'd1 || record_clip_o !== 4'hF) begin
            errors++;
            $display("FAIL play+next: playing=%b play=%h rec=%h expected 1 1 F", playing_o, play_clip_o, record_clip_o);
        end
    endtask

    task automatic test_stop_and_done();
        btn_play_i = 1'b1;
        repeat (6) @(negedge clock_i);
        clip_done_i = 1'b1;
        @(negedge clock_i);
        clip_done_i = 1'b0;
        checks++;
        if (playing_o !== 1'b0 || state_o !== IDLE || record_clip_o !== 4'd1 || play_clip_o !== 4'hF) begin
            errors++;
            $display("FAIL stop+done: playing=%b state=%0d rec=%h play=%h expected 0 IDLE 1 F",
                     playing_o, state_o, record_clip_o, play_clip_o);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_i);
            checks++;
            if (playing_o !== 1'b0) begin
                errors++;
                $display("FAIL stop+done hold %0d: playing=%b expected 0", i, playing_o);
            end
        end
        repeat (2) @(negedge clock_i);
        btn_play_i = 1'b0;
        repeat (10) @(negedge clock_i);
        checks++;
        if (playing_o !== 1'b0 || state_o !== IDLE) begin
            errors++;
            $display("FAIL after stop+done: playing=%b state=%0d expected 0 IDLE", playing_o, state_o);
        end
    endtask

    task automatic test_idle_done_and_rerecord();
        clip_done_i = 1'b1;
        @(negedge clock_i);
        clip_done_i = 1'b0;
        @(negedge clock_i);
        checks++;
        if (state_o !== IDLE || recording_o !== 1'b0 || playing_o !== 1'b0 || record_clip_o !== 4'd1) begin
            errors++;
            $display("FAIL done in idle: state=%0d r=%b p=%b rec=%h expected IDLE 0 0 1",
                     state_o, recording_o, playing_o, record_clip_o);
        end
        press(4'b0100);
        press(4'b0100);
        checks++;
        if (recording_o !== 1'b0 || clip_valid_o !== 10'b0000000010) begin
            errors++;
            $display("FAIL re-record: recording=%b valid=%b expected 0 0000000010", recording_o, clip_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_play_unrecorded();
        test_reset_mid_play();
        test_bounce();
        test_simultaneous();
        test_stop_and_done();
        test_idle_done_and_rerecord();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clip_controller.md
# clip_controller

Front-panel control stage for the clip recorder. It debounces the four raw push-buttons and tracks the selected clip index. It runs the idle/record/play state machine and produces the 4-bit clip numbers driven straight into the seven-segment display stage, along with the record/play enables for the audio path. A value of 4'hF on either clip output is the display's "blank" code.

## Interface
- SYSTEM_FREQUENCY, 100000000: clock rate in Hz; documentation only.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level (10 ms at 100 MHz); must be ≥ 2.
- NUM_CLIPS, 10: number of clip slots; range 1..10 so every index is a displayable digit.

Ports:
- clock_i  in  1  system clock; all logic on posedge.
- reset_i  in  1  asynchronous, active-low reset.
- btn_next_i  in  1  raw asynchronous button: select next clip.
- btn_prev_i  in  1  raw asynchronous button: select previous clip.
- btn_record_i  in  1  raw asynchronous button: start/stop recording.
- btn_play_i  in  1  raw asynchronous button: start/stop playback.
- clip_done_i  in  1  one-cycle pulse from the audio path: end of clip data or memory full.
- record_clip_o  out  4  selected clip index (selection cursor) in IDLE and RECORD; 4'hF in PLAY.
- play_clip_o  out  4  selected index while in PLAY; 4'hF otherwise.
- recording_o  out  1  high while in RECORD.
- playing_o  out  1  high while in PLAY.
- clip_valid_o  out  NUM_CLIPS  bit k set once clip k has been recorded.

## Operation
- Each button passes through a debouncer:
  - 2-FF synchronizer.
  - Counter of consecutive cycles where the synchronized level ≠ the accepted level. The counter clears on any match.
  - When the count reaches DEBOUNCE_CYCLES, the accepted level flips.
  - A 0→1 flip emits a one-cycle press pulse. Release emits nothing.
- The selection register sel is in 0..NUM_CLIPS-1.
  - next: sel+1, wrapping NUM_CLIPS-1→0.
  - prev: sel-1, wrapping 0→NUM_CLIPS-1.
  - next and prev act only in IDLE.
- FSM states IDLE, RECORD, PLAY:
  - IDLE + record press → RECORD.
  - IDLE + play press, with clip_valid[sel]=1 → PLAY. With clip_valid[sel]=0 the press is ignored and the state stays IDLE.
  - RECORD + (record press or clip_done_i) → IDLE, and clip_valid[sel] is set. Play, next and prev presses are ignored.
  - PLAY + (play press or clip_done_i) → IDLE. Record, next and prev presses are ignored.
- Simultaneous events in IDLE: priority record > play > next > prev. Only the highest-priority event acts; the others are dropped.
- Stop press and clip_done_i in the same cycle produce a single transition to IDLE.
- clip_done_i arriving in IDLE is ignored.
- Re-recording a valid clip is allowed; its valid bit stays set.

## Timing
- Reset values (asynchronous):
  - state=IDLE, sel=0, clip_valid_o=0.
  - record_clip_o=4'h0, play_clip_o=4'hF, recording_o=0, playing_o=0.
  - Debouncer accepted levels=0, counters=0.
- While reset is asserted mid-RECORD or mid-PLAY, the block returns to IDLE immediately and all recorded-valid state is lost.
- All outputs are registered.
- Latency:
  - A raw button held high from cycle 0 produces its press pulse in cycle DEBOUNCE_CYCLES+2.
  - Outputs reflect the resulting action at cycle DEBOUNCE_CYCLES+3.
  - clip_done_i at cycle t gives outputs updated at t+1.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- Holding a button produces exactly one pulse.

## Structure
- Shared package clip_pkg holds:
  - enum clip_state_t {IDLE, RECORD, PLAY}.
  - localparam CLIP_NONE = 4'hF.
  - The clip index type logic [3:0].
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clock_i, reset_i, button_i, pressed_o) is instantiated four times.
- The top level holds sel, clip_valid and the FSM.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_CLIPS=10.
- Reset mid-PLAY → within the same cycle: record_clip_o=0, play_clip_o=4'hF, recording_o=playing_o=0, clip_valid_o=0.
- Three prev presses from reset → record_clip_o 9, 8, 7. Then four next presses → 8, 9, 0, 1.
- Play press on unrecorded clip 0 → stays IDLE, play_clip_o=4'hF. Then: record press (recording_o=1), then clip_done_i pulse → recording_o=0 and clip_valid_o[0]=1. Then play press → playing_o=1, play_clip_o=0, record_clip_o=4'hF.
- Button held high 3 cycles then low, repeated 5 times → no state change. Held 10 cycles → exactly one pulse, with the output change at cycle 7 after the rise.
- Record and next pulses in the same IDLE cycle → RECORD entered, sel unchanged. Next press during RECORD → sel unchanged.
- In PLAY, play press and clip_done_i in the same cycle → single return to IDLE, with playing_o low for ≥ 2 following cycles.
